// File: rtl/delay_pkg.sv
// ============================================================================
// Module      : delay_pkg
// Description : Shared helpers for the stallable multi-lane delay line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_pkg;

  localparam int DEFAULT_MAX_DEPTH = 16;

  // Width needed to hold any value 0..max inclusive.
  function automatic int depth_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  function automatic int clamp_depth(input int d, input int max);
    if (d < 1)   return 1;
    if (d > max) return max;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_line_mem.sv
// ============================================================================
// Module      : delay_line_mem
// Description : Register-file storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 48,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/stall_delay_line.sv
// ============================================================================
// Module      : stall_delay_line
// Description : Multi-lane stallable delay line, runtime-programmable depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH     = 24,
  parameter  int LANES     = 2,
  parameter  int MAX_DEPTH = DEFAULT_MAX_DEPTH,
  localparam int DW        = depth_width(MAX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   cfg_load,
  input  logic [DW-1:0]          cfg_depth,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [DW-1:0]          occupancy,
  output logic                   empty
);

  localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [MAX_DEPTH-1:0] vld_q, vld_d;
  logic [DW-1:0]        occ_q, occ_d;

  logic                   adv;
  logic [LANES*WIDTH-1:0] rd_data;
  lane_vec_t              rd_lanes;

  assign adv = en && !flush && !cfg_load;

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    vld_d   = vld_q;
    occ_d   = occ_q;
    if (cfg_load) begin
      depth_d = DW'(clamp_depth(int'(cfg_depth), MAX_DEPTH));
      ptr_d   = '0;
      vld_d   = '0;
      occ_d   = '0;
    end else if (flush) begin
      ptr_d = '0;
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      vld_d[ptr_q] = in_valid;
      // Wrap at the programmed depth, not at MAX_DEPTH.
      ptr_d = (DW'(ptr_q) == depth_q - DW'(1)) ? '0 : ptr_q + PW'(1);
      occ_d = occ_q + DW'(in_valid) - DW'(vld_q[ptr_q]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      depth_q <= DW'(MAX_DEPTH);
      vld_q   <= '0;
      occ_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      vld_q   <= vld_d;
      occ_q   <= occ_d;
    end
  end

  delay_line_mem #(
    .DEPTH  (MAX_DEPTH),
    .DATA_W (LANES*WIDTH),
    .AW     (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (adv),
    .waddr_i (ptr_q),
    .wdata_i (in_data),
    .raddr_i (ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_lanes  = rd_data;
  assign out_valid = vld_q[ptr_q];
  assign out_data  = out_valid ? rd_lanes : '0;
  assign occupancy = occ_q;
  assign empty     = (occ_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_stall_delay_line.sv
// ============================================================================
// Module      : tb_stall_delay_line
// Description : Randomised self-checking bench against a fixed-length queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_delay_line;

  logic        clk, rst, en, flush, cfg_load, in_valid;
  logic [4:0]  cfg_depth;
  logic [47:0] in_data;
  logic        out_valid, empty;
  logic [47:0] out_data;
  logic [4:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the line is a queue of exactly m_depth slots {valid,data};
  // the head is what the output shows, each advance pops it and appends the input.
  logic [48:0] pipe [$];
  int          m_depth;

  stall_delay_line dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .cfg_load  (cfg_load),
    .cfg_depth (cfg_depth),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < m_depth; i++) pipe.push_back(49'd0);
  endtask

  task automatic check_all(input string tag);
    logic [48:0] head;
    int occ;
    head = pipe[0];
    occ  = 0;
    foreach (pipe[i]) if (pipe[i][48]) occ++;
    check({tag, ".vld"}, 64'(out_valid), 64'(head[48]));
    check({tag, ".dat"}, 64'(out_data), head[48] ? 64'(head[47:0]) : 64'd0);
    check({tag, ".occ"}, 64'(occupancy), 64'(occ));
    check({tag, ".emp"}, 64'(empty), 64'(occ == 0));
  endtask

  // Drive one cycle, apply the rules to the model at the edge, check at negedge.
  task automatic cyc(input string tag, input logic e, input logic f, input logic cl,
                     input logic [4:0] cd, input logic iv, input logic [47:0] d);
    en = e; flush = f; cfg_load = cl; cfg_depth = cd; in_valid = iv; in_data = d;
    @(posedge clk);
    if (cl) begin
      m_depth = (cd == 0) ? 1 : (cd > 16) ? 16 : int'(cd);
      model_clear();
    end else if (f) begin
      model_clear();
    end else if (e) begin
      void'(pipe.pop_front());
      pipe.push_back({iv, d});
    end
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  initial begin
    logic [0:6] pat;
    int k;
    rst = 1'b1; en = 0; flush = 0; cfg_load = 0; cfg_depth = 0; in_valid = 0; in_data = 0;
    m_depth = 16;
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Default depth 16, continuous stream 1,2,3...
    for (int i = 1; i <= 24; i++) cyc("t1", 1, 0, 0, 0, 1, 48'(i));

    // Depth 3 with stalls
    cyc("t2.cfg", 1, 0, 1, 5'd3, 1, 48'hAAA);
    pat = 7'b1011011;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      cyc("t2", pat[i], 0, 0, 0, pat[i], 48'hA0 + 48'(k));
      if (pat[i]) k++;
    end
    for (int i = 0; i < 5; i++) cyc("t2.drain", 1, 0, 0, 0, 0, 48'h0);

    // Depth 1, 0 (treated as 1), 31 (clamped to 16)
    foreach (pat[j]) begin end
    cyc("t3.d1", 0, 0, 1, 5'd1, 0, 0);
    for (int i = 0; i < 6; i++) cyc("t3.d1", 1, 0, 0, 0, 1, rnd48());
    cyc("t3.d0", 1, 0, 1, 5'd0, 1, rnd48());
    for (int i = 0; i < 6; i++) cyc("t3.d0", 1, 0, 0, 0, 1, rnd48());
    cyc("t3.d31", 1, 0, 1, 5'd31, 1, rnd48());
    for (int i = 0; i < 20; i++) cyc("t3.d31", 1, 0, 0, 0, 1, rnd48());

    // Depth 4, sparse valid, then flush mid-stream
    cyc("t4.cfg", 0, 0, 1, 5'd4, 0, 0);
    for (int i = 0; i < 6; i++) cyc("t4", 1, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3), rnd48());
    cyc("t4.flush", 1, 1, 0, 0, 1, rnd48());
    check("t4.flush_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 6; i++) cyc("t4.post", 1, 0, 0, 0, 0, rnd48());

    // flush + cfg_load together with a valid advancing input
    cyc("t5.pre", 1, 0, 0, 0, 1, rnd48());
    cyc("t5", 1, 1, 1, 5'd2, 1, rnd48());
    for (int i = 0; i < 5; i++) cyc("t5.post", 1, 0, 0, 0, 1, rnd48());

    // Async reset with occupancy 4
    cyc("t6.cfg", 0, 0, 1, 5'd4, 0, 0);
    for (int i = 0; i < 4; i++) cyc("t6.fill", 1, 0, 0, 0, 1, rnd48());
    check("t6.occ4", 64'(occupancy), 64'd4);
    en = 0;
    #2 rst = 1'b1;
    #1;
    check("t6.rst_vld", 64'(out_valid), 64'd0);
    check("t6.rst_dat", 64'(out_data), 64'd0);
    check("t6.rst_occ", 64'(occupancy), 64'd0);
    check("t6.rst_emp", 64'(empty), 64'd1);
    m_depth = 16;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check_all("t6.after_rst");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0),
          ($urandom_range(0, 80) == 0), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 2) != 0), rnd48());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
